// File: rtl/tbuart_tx.sv
// tbuart_tx: UART transmitter (8N1/8N2) fed from a small byte FIFO.
// Ports:
//   clock, resetb       rising-edge clock, asynchronous active-low reset
//   tx_data, tx_valid   byte source; a byte transfers on tx_valid & tx_ready
//   tx_ready            FIFO not full (registered)
//   ser_tx              serial line, idle high (registered)
//   busy                frame in progress or bytes queued (registered)
//   tx_done             one-cycle pulse when a frame's last stop bit ends
//   fifo_count          bytes queued, excluding the byte being shifted
module tbuart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               ser_tx,
    output logic               busy,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int unsigned DEPTH  = 2**FIFO_AW;
    localparam int unsigned CW     = FIFO_AW + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_d;
    logic [BAUD_W-1:0]   baud_cnt, baud_d;
    logic [2:0]          bit_cnt, bit_d;
    logic [7:0]          shift_reg, shift_d;
    logic                ser_tx_d;
    logic                tx_done_d;
    logic                busy_d;
    logic                pop;
    logic                push;
    logic                baud_end;

    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]       count_d;
    logic [7:0]          head;

    // tx_ready is the registered not-full flag, so a same-cycle pop never frees a slot
    assign push     = tx_valid & tx_ready;
    assign head     = mem[rd_ptr];
    assign baud_end = (baud_cnt == BAUD_LAST);

    // FIFO occupancy next value
    always_comb begin
        count_d = fifo_count;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CW'(1);
            2'b01:   count_d = fifo_count - CW'(1);
            default: count_d = fifo_count;
        endcase
    end

    assign busy_d = (state_d != IDLE) | (count_d != '0);

    // FIFO storage; payload needs no reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, count and ready flag
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            fifo_count <= count_d;
            tx_ready   <= (count_d != FULL_CNT);
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ser_tx    <= 1'b1;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_cnt   <= bit_d;
            shift_reg <= shift_d;
            ser_tx    <= ser_tx_d;
            tx_done   <= tx_done_d;
            busy      <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state;
        baud_d    = baud_cnt;
        bit_d     = bit_cnt;
        shift_d   = shift_reg;
        ser_tx_d  = ser_tx;
        tx_done_d = 1'b0;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                ser_tx_d = 1'b1;
                if (fifo_count != '0) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    ser_tx_d = 1'b0;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d   = '0;
                    bit_d    = '0;
                    ser_tx_d = shift_reg[0];
                    state_d  = DATA;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        ser_tx_d = 1'b1;
                        bit_d    = '0;
                        state_d  = STOP;
                    end else begin
                        ser_tx_d = shift_reg[1];
                        bit_d    = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                // bit_cnt counts stop bits here
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_cnt == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        bit_d     = '0;
                        if (fifo_count != '0) begin
                            // back-to-back frame: start bit right after the stop bit
                            pop      = 1'b1;
                            shift_d  = head;
                            ser_tx_d = 1'b0;
                            state_d  = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                ser_tx_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tbuart_tx.sv
// tb_tbuart_tx: directed bench for tbuart_tx (4 clocks/bit; one 8N1 and one 8N2 instance).
module tb_tbuart_tx;

    logic       clock = 1'b0;
    logic       resetb;
    logic [7:0] tx_data, tx_data_2;
    logic       tx_valid, tx_valid_2;
    logic       tx_ready, ser_tx, busy, tx_done;
    logic       tx_ready_2, ser_tx_2, busy_2, tx_done_2;
    logic [2:0] fifo_count, fifo_count_2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tbuart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_AW(2)) u_dut (
        .clock(clock), .resetb(resetb), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ser_tx(ser_tx), .busy(busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    tbuart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .FIFO_AW(2)) u_dut2 (
        .clock(clock), .resetb(resetb), .tx_data(tx_data_2), .tx_valid(tx_valid_2),
        .tx_ready(tx_ready_2), .ser_tx(ser_tx_2), .busy(busy_2), .tx_done(tx_done_2),
        .fifo_count(fifo_count_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // wait (bounded) until ser_tx drops for a start bit
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (ser_tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(ser_tx === 1'b0), 32'd1);
    endtask

    // called at cycle 0 of the start bit; returns at the cycle the frame ends
    task automatic recv_byte(output logic [7:0] b);
        repeat (2) tick();
        check("rx_start_bit", 32'(ser_tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (4) tick();
            b[j] = ser_tx;
        end
        repeat (4) tick();
        check("rx_stop_bit", 32'(ser_tx), 32'd1);
        repeat (2) tick();
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] rb;
        int         n;

        resetb     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_valid_2 = 1'b0;
        tx_data_2  = 8'h00;
        repeat (3) tick();

        // reset state
        check("rst_ser_tx",  32'(ser_tx),     32'd1);
        check("rst_ready",   32'(tx_ready),   32'd1);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(tx_done),    32'd0);
        check("rst_count",   32'(fifo_count), 32'd0);
        resetb = 1'b1;
        tick();

        // test 1: single byte A5, start edge one cycle after the push
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check("t1_count_after_push", 32'(fifo_count), 32'd1);
        check("t1_idle_high",        32'(ser_tx),     32'd1);
        check("t1_busy",             32'(busy),       32'd1);
        tick();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check("t1_ser_tx", 32'(ser_tx),  32'(frame[i/4]));
            check("t1_no_done", 32'(tx_done), 32'd0);
            tick();
        end
        check("t1_done_at_40", 32'(tx_done), 32'd1);
        check("t1_end_high",   32'(ser_tx),  32'd1);
        check("t1_end_busy",   32'(busy),    32'd0);
        tick();
        check("t1_done_pulse", 32'(tx_done), 32'd0);
        repeat (3) tick();

        // tests 2 and 3: six bytes back-to-back, full-FIFO push blocked on the pop edge
        fork
            begin : drv
                int w;
                for (int k = 0; k < 6; k++) begin
                    tx_data  = 8'(k);
                    tx_valid = 1'b1;
                    w = 0;
                    while (!tx_ready && w < 100) begin
                        tick();
                        w++;
                    end
                    check("t2_ready_wait", 32'(tx_ready), 32'd1);
                    if (k == 5) check("t3_count_after_pop", 32'(fifo_count), 32'd3);
                    tick();
                    if (k == 4) begin
                        check("t2_full_ready", 32'(tx_ready),   32'd0);
                        check("t2_full_count", 32'(fifo_count), 32'd4);
                    end
                    if (k == 5) check("t3_push_next_cycle", 32'(fifo_count), 32'd4);
                end
                tx_valid = 1'b0;
            end
            begin : rcv
                int unsigned prev;
                logic [7:0]  b;
                prev = 0;
                for (int f = 0; f < 6; f++) begin
                    wait_start("t2_start_seen");
                    if (f > 0) check("t2_gap", 32'(cyc - prev), 32'd40);
                    prev = cyc;
                    recv_byte(b);
                    check("t2_byte", 32'(b), 32'(f));
                    check("t2_done", 32'(tx_done), 32'd1);
                end
            end
        join
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("t2_idle_busy",  32'(busy),       32'd0);
        check("t2_idle_count", 32'(fifo_count), 32'd0);

        // test 4: reset during data bit 3 of FF with one byte queued
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("t4_start", 32'(ser_tx), 32'd0);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (17) tick();
        check("t4_bit3_high",    32'(ser_tx),     32'd1);
        check("t4_count_before", 32'(fifo_count), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("t4_rst_ser_tx", 32'(ser_tx),     32'd1);
        check("t4_rst_busy",   32'(busy),       32'd0);
        check("t4_rst_count",  32'(fifo_count), 32'd0);
        check("t4_rst_ready",  32'(tx_ready),   32'd1);
        check("t4_rst_done",   32'(tx_done),    32'd0);
        tick();
        tick();
        check("t4_in_rst_done", 32'(tx_done), 32'd0);
        resetb = 1'b1;
        tick();
        check("t4_post_done", 32'(tx_done), 32'd0);
        check("t4_post_ser",  32'(ser_tx),  32'd1);
        check("t4_post_busy", 32'(busy),    32'd0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("t4_3c_start", 32'(ser_tx), 32'd0);
        recv_byte(rb);
        check("t4_3c_byte", 32'(rb),      32'h3C);
        check("t4_3c_done", 32'(tx_done), 32'd1);
        tick();
        check("t4_3c_done_off", 32'(tx_done), 32'd0);
        check("t4_3c_idle",     32'(busy),    32'd0);

        // test 5: two stop bits, 44-cycle frame
        tx_data_2  = 8'h00;
        tx_valid_2 = 1'b1;
        tick();
        tx_valid_2 = 1'b0;
        tick();
        for (int k = 0; k <= 44; k++) begin
            check("t5_ser_tx", 32'(ser_tx_2),  32'(k >= 36));
            check("t5_done",   32'(tx_done_2), 32'(k == 44));
            if (k < 44) tick();
        end
        check("t5_busy_end", 32'(busy_2), 32'd0);
        tick();
        check("t5_done_off", 32'(tx_done_2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
